// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the scheduled serial pattern detector.
// The MATCH_CNT_EN build option is handled in seq_det_sched; nothing here depends on it.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int NCH_DEF = 4;
  localparam logic [3:0] PAT_RST_DEF = 4'b1011;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Per-channel serial request bundle between the bit sources and the scheduler.
// Source holds seq_valid/seq; a bit is taken in any cycle its seq_ready bit is also high.
interface seq_det_sched_if #(
  parameter int NCH = 4
);

  logic [NCH-1:0] seq_valid;
  logic [NCH-1:0] seq;
  logic [NCH-1:0] seq_ready;

  modport master (
    output seq_valid,
    output seq,
    input  seq_ready
  );

  modport slave (
    input  seq_valid,
    input  seq,
    output seq_ready
  );

endinterface

// File: rtl/seq_det_sched_rr_arb.sv
// rr_arb: picks the first requesting channel at or after ptr, searching modulo NCH.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; the caller masks gnt when it cannot accept a bit.
module rr_arb
  import seq_det_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int CH_W = ch_w(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [NCH-1:0]  gnt,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  logic [CH_W:0] slot;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    slot = '0;
    for (int k = 0; k < NCH; k++) begin
      // ptr + k stays below 2*NCH, so one conditional subtract gives the modulo.
      slot = {1'b0, ptr} + (CH_W+1)'(k);
      if (slot >= (CH_W+1)'(NCH)) begin
        slot = slot - (CH_W+1)'(NCH);
      end
      if (!any && req[slot[CH_W-1:0]]) begin
        any = 1'b1;
        idx = slot[CH_W-1:0];
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: one programmable pattern detector time-shared round-robin across NCH serial streams; MATCH_CNT_EN adds per-channel match counters.
// Latency: grant is combinational in the request cycle; dout pulses one cycle after the consuming cycle.
// Backpressure: one bit per cycle in aggregate; seq_ready stays low in IDLE, FLUSH and on the cfg_load cycle.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter  int               NCH     = NCH_DEF,
  parameter  int               PAT_W   = 4,
  parameter  logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  localparam int               CH_W    = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  seq_det_sched_if.slave   sif,
  output logic             dout,
  output logic [CH_W-1:0]  dout_ch,
  output logic             busy
`ifdef MATCH_CNT_EN
  ,
  output logic [NCH*8-1:0] match_cnt
`endif
);

  localparam int                FILL_W   = ch_w(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

  state_t            state_q;
  state_t            state_d;
  logic [CH_W-1:0]   ptr_q;
  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  hist_q [NCH];
  logic [FILL_W-1:0] fill_q [NCH];

  logic [NCH-1:0]    gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              arb_en;
  logic              fire;
  logic              hit;
  logic [PAT_W-1:0]  shifted;
  logic [CH_W-1:0]   ptr_nxt;

  rr_arb #(
    .NCH (NCH)
  ) u_arb (
    .req (sif.seq_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // A pending reconfiguration wins over a grant in the same cycle.
  assign arb_en        = (state_q == RUN) && en && !cfg_load;
  assign sif.seq_ready = arb_en ? gnt : '0;
  assign fire          = arb_en && gnt_any;
  assign busy          = (state_q == FLUSH);

  assign shifted = {hist_q[gnt_idx][PAT_W-2:0], sif.seq[gnt_idx]};
  assign hit     = fire && (shifted == pat_q) &&
                   (fill_q[gnt_idx] >= FILL_W'(PAT_W - 1));
  assign ptr_nxt = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (cfg_load)  state_d = FLUSH;
        else if (!en)  state_d = IDLE;
      end
      FLUSH: begin
        state_d = en ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      pat_q   <= PAT_RST;
      dout    <= 1'b0;
      dout_ch <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist_q[i] <= '0;
        fill_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dout    <= hit;
      if (hit) begin
        dout_ch <= gnt_idx;
      end
      if ((state_q == RUN) && cfg_load) begin
        pat_q <= cfg_pat;
      end
      if (fire) begin
        ptr_q           <= ptr_nxt;
        hist_q[gnt_idx] <= shifted;
        if (fill_q[gnt_idx] != FILL_MAX) begin
          fill_q[gnt_idx] <= fill_q[gnt_idx] + FILL_W'(1);
        end
      end
      // FLUSH never grants, so the clear cannot collide with a shift above.
      if (state_q == FLUSH) begin
        for (int i = 0; i < NCH; i++) begin
          hist_q[i] <= '0;
          fill_q[i] <= '0;
        end
      end
    end
  end

`ifdef MATCH_CNT_EN
  logic [7:0] cnt_q [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (state_q == FLUSH) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (hit && (cnt_q[gnt_idx] != 8'hFF)) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 8'd1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    assign match_cnt[i*8 +: 8] = cnt_q[i];
  end
`endif

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one programmable serial pattern detector among NCH independent bit-stream requesters. Each channel keeps its own shift history, so overlapping detection works per channel even though only one bit is evaluated per cycle. It sits between the serial sources and the downstream match consumer, and replaces one fixed FSM detector per stream.

## Interface
Parameters:
- NCH, 4: number of requesting channels (2..8).
- PAT_W, 4: pattern length in bits (2..8).
- PAT_RST, 4'b1011: pattern value loaded at reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; grants are issued only while en=1.
- cfg_load  in  1  one-cycle pulse that loads cfg_pat and flushes all histories.
- cfg_pat  in  PAT_W  new pattern. The MSB is the oldest bit.
- seq_valid  in  NCH  per-channel request; bit available on seq.
- seq  in  NCH  per-channel serial data bit.
- seq_ready  out  NCH  one-hot grant. A bit is consumed when seq_valid[i] and seq_ready[i] are both 1.
- dout  out  1  registered one-cycle match pulse.
- dout_ch  out  $clog2(NCH)  channel that produced the match. Held while dout=0.
- busy  out  1  high while the controller is in FLUSH.

## Operation
- Controller FSM has three states:
  - IDLE: reached from reset. Goes to RUN when en=1.
  - RUN: goes to FLUSH on cfg_load. Goes to IDLE when en=0 and cfg_load=0.
  - FLUSH: always lasts exactly one cycle. Then goes to RUN if en=1, otherwise IDLE.
- Arbitration:
  - The arbiter is combinational from seq_valid and the rotating pointer.
  - The grant goes to the first valid channel at or after ptr, searching modulo NCH.
  - seq_ready is all-zero in IDLE and FLUSH, and when no channel is valid.
- On each grant to channel g:
  - ptr <= (g+1) mod NCH.
  - hist[g] <= {hist[g][PAT_W-2:0], seq[g]}.
  - fill[g] <= min(fill[g]+1, PAT_W).
- Match condition: {hist[g][PAT_W-2:0], seq[g]} == pat and fill[g]+1 >= PAT_W. Pattern matches may overlap.
- FLUSH actions:
  - pat <= cfg_pat, latched on the cfg_load cycle.
  - All hist and fill are cleared.
  - ptr is unchanged.
- A cfg_load arriving while in FLUSH is ignored.

## Timing
- Reset values: seq_ready=0, dout=0, dout_ch=0, busy=0, state=IDLE, ptr=0, hist=0, fill=0, pat=PAT_RST.
- Grant latency is 0 cycles: seq_ready reacts combinationally to seq_valid.
- Match latency: dout rises in the cycle after the consuming cycle and lasts 1 cycle.
- Throughput is one bit per cycle in aggregate. With all channels valid, each channel gets 1 bit every NCH cycles.
- cfg_load during RUN:
  - No grant in the cfg_load cycle.
  - busy=1 during FLUSH.
  - First grant comes 2 cycles after the pulse.
  - The first match against the new pattern needs PAT_W fresh bits.
- When cfg_load and a match fall in the same cycle, no grant occurs, so no match is produced.
- Dropping en mid-stream keeps hist, fill and ptr. Detection resumes seamlessly when en returns.
- Asserting rst mid-operation clears everything immediately. A dout pulse in flight is lost.
- ptr wraps from NCH-1 to 0.

## Configuration
- Macro MATCH_CNT_EN.
- When defined:
  - Adds output match_cnt, width NCH*8: one 8-bit counter per channel.
  - A counter increments on each match of its channel and saturates at 255.
  - Counters are cleared by rst and by FLUSH.
  - Counters are updated in the same edge as dout.
- When undefined: the port and counters are absent, and all other behaviour is identical.

## Structure
- Package seq_det_pkg holds:
  - the state enum (IDLE, RUN, FLUSH);
  - localparam CH_W = $clog2(NCH), via a package function;
  - default PAT_RST.
- Sub-module rr_arb holds the combinational round-robin grant logic (seq_valid, ptr in; one-hot grant and encoded index out).
- Histories, fill counters, FSM and output registers stay in the top module.

## Test plan
- Single stream, default config (en=1, only ch0 valid, pattern 1011): seq 1,0,1,1,0,1,1 -> dout pulses twice (overlap), dout_ch=0, each pulse one cycle after the 4th and 7th bits.
- All-valid fairness (all 4 channels valid for 12 cycles): seq_ready sequence is 0001, 0010, 0100, 1000, then repeats; each channel receives exactly 3 grants.
- Interleaved detection (ch1 and ch3 both stream 1011 while ch0/ch2 idle): grants alternate between them; dout fires twice, dout_ch=1 then 3; no cross-channel false match.
- Reconfig mid-stream (cfg_load with cfg_pat=0110 after 3 bits into ch0): busy=1 for one cycle; the next 2 bits do not match; bits 0,1,1,0 then match once.
- Async reset (assert rst for 3 ns mid-RUN, off-edge): seq_ready=0, dout=0 and busy=0 immediately; pattern reverts to 1011; after release, 1 cycle in IDLE before the first grant.
- With MATCH_CNT_EN defined: feed 300 overlapping matches on ch2 -> match_cnt[23:16]=255, other counters 0; a FLUSH returns all counters to 0.
